// File: rtl/tod_pkg.sv
// Shared widths, limits and BCD helpers for the time-of-day clock.
package tod_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned TIME_W  = 24;
    localparam int unsigned ALARM_W = 16;

    localparam logic [BCD_W-1:0] MAX_HH = 8'h23;
    localparam logic [BCD_W-1:0] MAX_MS = 8'h59;

    // Both digits must be decimal; with decimal digits a binary compare orders BCD correctly.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] max);
        return (v[BCD_W-1:DIGIT_W] <= 4'd9) && (v[DIGIT_W-1:0] <= 4'd9) && (v <= max);
    endfunction

    // 24-hour BCD hour to 12-hour BCD hour; 20..23 need a decimal borrow so are listed.
    function automatic logic [BCD_W-1:0] decode_12h(input logic [BCD_W-1:0] hh);
        logic [BCD_W-1:0] r;
        case (hh)
            8'h00:   r = 8'h12;
            8'h20:   r = 8'h08;
            8'h21:   r = 8'h09;
            8'h22:   r = 8'h10;
            8'h23:   r = 8'h11;
            default: r = (hh > 8'h12) ? hh - 8'h12 : hh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_of_day_clock_if.sv
// Control/display bundle of the time-of-day clock; alarm signals exist only with TOD_ALARM_EN.
interface time_of_day_clock_if;
    import tod_pkg::*;

    logic               Enable;
    logic               Mode_12h;
    logic               Set_time;
    logic [TIME_W-1:0]  Time_in;
    logic [BCD_W-1:0]   Hours_out;
    logic [BCD_W-1:0]   Minutes_out;
    logic [BCD_W-1:0]   Seconds_out;
    logic               Pm_out;
    logic               Sec_tick;
    logic               Day_wrap;
    logic               Set_err;
`ifdef TOD_ALARM_EN
    logic               Alarm_set;
    logic [ALARM_W-1:0] Alarm_in;
    logic               Alarm_arm;
    logic               Alarm_hit;

    modport master (output Enable, Mode_12h, Set_time, Time_in, Alarm_set, Alarm_in, Alarm_arm,
                    input  Hours_out, Minutes_out, Seconds_out, Pm_out, Sec_tick, Day_wrap,
                           Set_err, Alarm_hit);
    modport slave  (input  Enable, Mode_12h, Set_time, Time_in, Alarm_set, Alarm_in, Alarm_arm,
                    output Hours_out, Minutes_out, Seconds_out, Pm_out, Sec_tick, Day_wrap,
                           Set_err, Alarm_hit);
`else
    modport master (output Enable, Mode_12h, Set_time, Time_in,
                    input  Hours_out, Minutes_out, Seconds_out, Pm_out, Sec_tick, Day_wrap,
                           Set_err);
    modport slave  (input  Enable, Mode_12h, Set_time, Time_in,
                    output Hours_out, Minutes_out, Seconds_out, Pm_out, Sec_tick, Day_wrap,
                           Set_err);
`endif

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping MAX->00 with synchronous load; load has priority over inc.
module bcd_mod_counter
    import tod_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 8'h59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    output logic [BCD_W-1:0] value_o,
    output logic [BCD_W-1:0] next_c,
    output logic             carry_c
);

    logic [BCD_W-1:0] value_q, value_d, inc_val;

    always_comb begin
        inc_val = '0;
        value_d = value_q;
        carry_c = inc_i && !load_i && (value_q == MAX);
        if (value_q == MAX) begin
            inc_val = '0;
        end else if (value_q[DIGIT_W-1:0] == 4'd9) begin
            inc_val = {value_q[BCD_W-1:DIGIT_W] + 4'd1, 4'd0};
        end else begin
            inc_val = {value_q[BCD_W-1:DIGIT_W], value_q[DIGIT_W-1:0] + 4'd1};
        end
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = inc_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value_o = value_q;
    assign next_c  = value_d;

endmodule

// File: rtl/time_of_day_clock.sv
// BCD HH:MM:SS clock with prescaled second tick, load validation and 12h display decode.
// Optional minute-resolution alarm when TOD_ALARM_EN is defined.
module time_of_day_clock
    import tod_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
    input  logic                Clk,
    input  logic                Reset_time_n,
    time_of_day_clock_if.slave  bus
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sec_tick_q, day_wrap_q, set_err_q;
    logic               time_ok_c, load_ok_c, wrap_c, advance_c, set_err_d;
    logic [BCD_W-1:0]   hh_in, mm_in, ss_in;
    logic [BCD_W-1:0]   hh, mm, ss, hh_nx, mm_nx, ss_nx;
    logic               ss_carry, mm_carry, hh_carry;

    assign hh_in = bus.Time_in[TIME_W-1:2*BCD_W];
    assign mm_in = bus.Time_in[2*BCD_W-1:BCD_W];
    assign ss_in = bus.Time_in[BCD_W-1:0];

    assign time_ok_c = bcd_valid(hh_in, MAX_HH) && bcd_valid(mm_in, MAX_MS) && bcd_valid(ss_in, MAX_MS);
    assign load_ok_c = bus.Set_time && time_ok_c;
    assign wrap_c    = bus.Enable && (presc_q == PRESC_LAST);
    // A load strobe swallows a coincident tick, whether or not the load is accepted.
    assign advance_c = wrap_c && !bus.Set_time;

    always_comb begin
        presc_d = presc_q;
        if (load_ok_c) begin
            presc_d = '0;
        end else if (bus.Enable && !bus.Set_time) begin
            presc_d = wrap_c ? '0 : presc_q + PRESC_W'(1);
        end
    end

    bcd_mod_counter #(.MAX(MAX_MS)) u_sec (
        .clk(Clk), .rst_n(Reset_time_n), .inc_i(advance_c), .load_i(load_ok_c),
        .load_val_i(ss_in), .value_o(ss), .next_c(ss_nx), .carry_c(ss_carry));

    bcd_mod_counter #(.MAX(MAX_MS)) u_min (
        .clk(Clk), .rst_n(Reset_time_n), .inc_i(ss_carry), .load_i(load_ok_c),
        .load_val_i(mm_in), .value_o(mm), .next_c(mm_nx), .carry_c(mm_carry));

    bcd_mod_counter #(.MAX(MAX_HH)) u_hour (
        .clk(Clk), .rst_n(Reset_time_n), .inc_i(mm_carry), .load_i(load_ok_c),
        .load_val_i(hh_in), .value_o(hh), .next_c(hh_nx), .carry_c(hh_carry));

`ifdef TOD_ALARM_EN
    logic [ALARM_W-1:0] alarm_q, alarm_d;
    logic               alarm_hit_q, alarm_hit_d, alarm_ok_c;

    assign alarm_ok_c = bcd_valid(bus.Alarm_in[ALARM_W-1:BCD_W], MAX_HH)
                     && bcd_valid(bus.Alarm_in[BCD_W-1:0], MAX_MS);
    assign alarm_d    = (bus.Alarm_set && alarm_ok_c) ? bus.Alarm_in : alarm_q;
    // Only a tick landing on second zero can hit, so a direct load never fires.
    assign alarm_hit_d = advance_c && bus.Alarm_arm && (ss_nx == 8'h00) && ({hh_nx, mm_nx} == alarm_q);
    assign set_err_d   = (bus.Set_time && !time_ok_c) || (bus.Alarm_set && !alarm_ok_c);

    always_ff @(posedge Clk or negedge Reset_time_n) begin
        if (!Reset_time_n) begin
            alarm_q     <= '0;
            alarm_hit_q <= 1'b0;
        end else begin
            alarm_q     <= alarm_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign bus.Alarm_hit = alarm_hit_q;
`else
    assign set_err_d = bus.Set_time && !time_ok_c;
`endif

    always_ff @(posedge Clk or negedge Reset_time_n) begin
        if (!Reset_time_n) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= advance_c;
            day_wrap_q <= hh_carry;
            set_err_q  <= set_err_d;
        end
    end

    assign bus.Hours_out   = bus.Mode_12h ? decode_12h(hh) : hh;
    assign bus.Minutes_out = mm;
    assign bus.Seconds_out = ss;
    assign bus.Pm_out      = (hh >= 8'h12);
    assign bus.Sec_tick    = sec_tick_q;
    assign bus.Day_wrap    = day_wrap_q;
    assign bus.Set_err     = set_err_q;

endmodule

// File: tb/tb_time_of_day_clock.sv
// Directed bench for time_of_day_clock at TICKS_PER_SEC=4; alarm checks need TOD_ALARM_EN.
module tb_time_of_day_clock;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    time_of_day_clock_if bus ();

    time_of_day_clock #(.TICKS_PER_SEC(4)) dut (
        .Clk          (clk),
        .Reset_time_n (rst_n),
        .bus          (bus)
    );

    typedef struct {
        logic [23:0] tin;
        logic        mode;
        logic [7:0]  hh, mm, ss;
        logic        pm;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_time(input string nm, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        chk({nm, " hours"},   32'(bus.Hours_out),   32'(h));
        chk({nm, " minutes"}, 32'(bus.Minutes_out), 32'(m));
        chk({nm, " seconds"}, 32'(bus.Seconds_out), 32'(s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] v);
        bus.Time_in  = v;
        bus.Set_time = 1'b1;
        step();
        bus.Set_time = 1'b0;
    endtask

    initial begin
        int ticks;
        int wraps;

        vecs[0]  = '{24'h130500, 1'b1, 8'h01, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{24'h120000, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{24'h000000, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{24'h115959, 1'b1, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0};
        vecs[4]  = '{24'h234530, 1'b1, 8'h11, 8'h45, 8'h30, 1'b1, 1'b0};
        vecs[5]  = '{24'h200000, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{24'h240000, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{24'h127A00, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{24'h096000, 1'b1, 8'h08, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{24'h010203, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[10] = '{24'h1A0000, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1};
        vecs[11] = '{24'h195900, 1'b1, 8'h07, 8'h59, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{24'h000060, 1'b0, 8'h19, 8'h59, 8'h00, 1'b1, 1'b1};

        rst_n        = 1'b0;
        bus.Enable   = 1'b0;
        bus.Mode_12h = 1'b0;
        bus.Set_time = 1'b0;
        bus.Time_in  = '0;
`ifdef TOD_ALARM_EN
        bus.Alarm_set = 1'b0;
        bus.Alarm_in  = '0;
        bus.Alarm_arm = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state
        chk_time("reset", 8'h00, 8'h00, 8'h00);
        chk("reset pm",       32'(bus.Pm_out),   32'd0);
        chk("reset sec_tick", 32'(bus.Sec_tick), 32'd0);
        chk("reset day_wrap", 32'(bus.Day_wrap), 32'd0);
        chk("reset set_err",  32'(bus.Set_err),  32'd0);
        bus.Mode_12h = 1'b1;
        #1 chk("reset 12h hours", 32'(bus.Hours_out), 32'h12);

        // Loads and display decode with the prescaler stopped
        foreach (vecs[i]) begin
            bus.Mode_12h = vecs[i].mode;
            load(vecs[i].tin);
            chk_time($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss);
            chk($sformatf("vec%0d pm", i),      32'(bus.Pm_out),  32'(vecs[i].pm));
            chk($sformatf("vec%0d set_err", i), 32'(bus.Set_err), 32'(vecs[i].err));
        end
        step();
        chk("set_err one cycle", 32'(bus.Set_err), 32'd0);

        // Midnight rollover: 5 ticks over 20 cycles
        bus.Mode_12h = 1'b0;
        bus.Enable   = 1'b1;
        load(24'h235955);
        ticks = 0;
        wraps = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.Sec_tick) ticks++;
            if (bus.Day_wrap) wraps++;
            if (c == 20) begin
                chk_time("rollover", 8'h00, 8'h00, 8'h00);
                chk("rollover day_wrap", 32'(bus.Day_wrap), 32'd1);
                chk("rollover pm",       32'(bus.Pm_out),   32'd0);
            end
        end
        chk("rollover tick count", 32'(ticks), 32'd5);
        chk("rollover wrap count", 32'(wraps), 32'd1);
        step();
        chk("day_wrap one cycle", 32'(bus.Day_wrap), 32'd0);

        // Load on the prescaler wrap cycle discards the tick
        load(24'h050000);
        repeat (3) step();
        load(24'h100000);
        chk_time("set on wrap", 8'h10, 8'h00, 8'h00);
        chk("set on wrap sec_tick", 32'(bus.Sec_tick), 32'd0);
        repeat (3) step();
        chk("post-set seconds before tick", 32'(bus.Seconds_out), 32'h00);
        chk("post-set no early tick",       32'(bus.Sec_tick),    32'd0);
        step();
        chk_time("post-set first tick", 8'h10, 8'h00, 8'h01);
        chk("post-set sec_tick", 32'(bus.Sec_tick), 32'd1);

        // Enable low holds time and prescaler
        bus.Enable = 1'b0;
        ticks = 0;
        repeat (8) begin
            step();
            if (bus.Sec_tick) ticks++;
        end
        chk_time("hold", 8'h10, 8'h00, 8'h01);
        chk("hold ticks", 32'(ticks), 32'd0);

        // Asynchronous reset mid-count restarts cleanly
        bus.Enable = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1 chk_time("async reset", 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ticks = 0;
        repeat (3) begin
            step();
            if (bus.Sec_tick || bus.Day_wrap || bus.Set_err) ticks++;
        end
        chk("no pulse after reset", 32'(ticks), 32'd0);
        step();
        chk_time("first tick after reset", 8'h00, 8'h00, 8'h01);
        chk("first tick after reset pulse", 32'(bus.Sec_tick), 32'd1);
        bus.Enable = 1'b0;

`ifdef TOD_ALARM_EN
        bus.Alarm_in  = 16'h0630;
        bus.Alarm_set = 1'b1;
        step();
        bus.Alarm_set = 1'b0;
        chk("alarm valid set_err", 32'(bus.Set_err), 32'd0);
        bus.Alarm_in  = 16'h2500;
        bus.Alarm_set = 1'b1;
        step();
        bus.Alarm_set = 1'b0;
        chk("alarm invalid set_err", 32'(bus.Set_err), 32'd1);

        bus.Alarm_arm = 1'b1;
        bus.Enable    = 1'b1;
        load(24'h062958);
        ticks = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (bus.Alarm_hit) ticks++;
            if (c == 8) begin
                chk_time("alarm time", 8'h06, 8'h30, 8'h00);
                chk("alarm hit", 32'(bus.Alarm_hit), 32'd1);
                chk("alarm with tick", 32'(bus.Sec_tick), 32'd1);
            end
        end
        chk("alarm hit count", 32'(ticks), 32'd1);

        load(24'h063000);
        ticks = bus.Alarm_hit ? 1 : 0;
        repeat (4) begin
            step();
            if (bus.Alarm_hit) ticks++;
        end
        chk("alarm no hit on load", 32'(ticks), 32'd0);
        bus.Enable    = 1'b0;
        bus.Alarm_arm = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
